// File: rtl/priority_demux_if.sv
// Tagged input stream and per-channel output bundle
// for the priority demultiplexer.
interface priority_demux_if #(
  parameter int N_PRIORITY_WIDTH = 2,
  parameter int N_SIGNAL_WIDTH   = 8,
  parameter int N_SIGNALS        = 4,
  parameter int N_FIFO_DEPTH     = 4
);
  localparam int CW = $clog2(N_FIFO_DEPTH) + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [N_SIGNAL_WIDTH-1:0]     in_data;
  logic [N_PRIORITY_WIDTH-1:0]   in_priority;
  logic [N_SIGNALS-1:0]          out_valid;
  logic [N_SIGNALS-1:0]          out_ready;
  logic [N_SIGNALS*N_SIGNAL_WIDTH-1:0] out_data;
  logic [N_SIGNALS*CW-1:0]       out_count;
  logic                          err_invalid;
  logic [7:0]                    drop_count;

  modport master (
    output in_valid,
    output in_data,
    output in_priority,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_count,
    input  err_invalid,
    input  drop_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_priority,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_count,
    output err_invalid,
    output drop_count
  );
endinterface

// File: rtl/priority_demux.sv
// Routes a tagged stream into per-channel FIFOs that
// drain independently; out-of-range tags are dropped.
module priority_demux #(
  parameter int N_PRIORITY_WIDTH = 2,
  parameter int N_SIGNAL_WIDTH   = 8,
  parameter int N_SIGNALS        = 4,
  parameter int N_FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic rst,
  priority_demux_if.slave bus
);
  localparam int AW = $clog2(N_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = N_SIGNAL_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(N_FIFO_DEPTH);

  logic [W-1:0]  mem_q  [N_SIGNALS][N_FIFO_DEPTH];
  logic [AW-1:0] wptr_q [N_SIGNALS];
  logic [AW-1:0] wptr_d [N_SIGNALS];
  logic [AW-1:0] rptr_q [N_SIGNALS];
  logic [AW-1:0] rptr_d [N_SIGNALS];
  logic [CW-1:0] cnt_q  [N_SIGNALS];
  logic [CW-1:0] cnt_d  [N_SIGNALS];
  logic          err_q;
  logic          err_d;
  logic [7:0]    drop_q;
  logic [7:0]    drop_d;

  logic                 tag_ok;
  logic                 sel_full;
  logic                 ready;
  logic                 accept;
  logic [N_SIGNALS-1:0] push;
  logic [N_SIGNALS-1:0] pop;

  // Fullness comes from the pre-pop count: no same-cycle bypass.
  always_comb begin
    tag_ok   = int'(bus.in_priority) < N_SIGNALS;
    sel_full = 1'b0;
    for (int i = 0; i < N_SIGNALS; i++) begin
      if (int'(bus.in_priority) == i) begin
        sel_full = (cnt_q[i] == FULL);
      end
    end
    ready  = !rst && (!tag_ok || !sel_full);
    accept = bus.in_valid && ready;
    push   = '0;
    pop    = '0;
    for (int i = 0; i < N_SIGNALS; i++) begin
      push[i] = accept && (int'(bus.in_priority) == i);
      pop[i]  = (cnt_q[i] != '0) && bus.out_ready[i];
    end
  end

  assign bus.in_ready = ready;

  always_comb begin
    for (int i = 0; i < N_SIGNALS; i++) begin
      wptr_d[i] = wptr_q[i] + AW'(push[i]);
      rptr_d[i] = rptr_q[i] + AW'(pop[i]);
      cnt_d[i]  = cnt_q[i];
      unique case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    err_d  = accept && !tag_ok;
    drop_d = drop_q;
    if (err_d && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SIGNALS; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q  <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      for (int i = 0; i < N_SIGNALS; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SIGNALS; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= bus.in_data;
      end
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    bus.out_count = '0;
    for (int i = 0; i < N_SIGNALS; i++) begin
      bus.out_valid[i]          = (cnt_q[i] != '0);
      bus.out_data[i*W +: W]    = mem_q[i][rptr_q[i]];
      bus.out_count[i*CW +: CW] = cnt_q[i];
    end
  end

  assign bus.err_invalid = err_q;
  assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_priority_demux.sv
// Two demux instances (4 and 3 channels) driven by one stream
// and compared against per-channel queue models.
module tb_priority_demux;
  logic clk;
  logic rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_priority;
  logic [3:0] out_ready;

  int errors = 0;
  int checks = 0;

  priority_demux_if #(.N_PRIORITY_WIDTH(2), .N_SIGNAL_WIDTH(8),
    .N_SIGNALS(4), .N_FIFO_DEPTH(4)) bus0 ();
  priority_demux_if #(.N_PRIORITY_WIDTH(2), .N_SIGNAL_WIDTH(8),
    .N_SIGNALS(3), .N_FIFO_DEPTH(4)) bus1 ();

  priority_demux #(.N_PRIORITY_WIDTH(2), .N_SIGNAL_WIDTH(8),
    .N_SIGNALS(4), .N_FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  priority_demux #(.N_PRIORITY_WIDTH(2), .N_SIGNAL_WIDTH(8),
    .N_SIGNALS(3), .N_FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  assign bus0.in_valid    = in_valid;
  assign bus0.in_data     = in_data;
  assign bus0.in_priority = in_priority;
  assign bus0.out_ready   = out_ready;
  assign bus1.in_valid    = in_valid;
  assign bus1.in_data     = in_data;
  assign bus1.in_priority = in_priority;
  assign bus1.out_ready   = out_ready[2:0];

  logic        rdy  [2];
  logic [3:0]  ovld [2];
  logic [31:0] odat [2];
  logic [11:0] ocnt [2];
  logic        oerr [2];
  logic [7:0]  dcnt [2];

  assign rdy[0]  = bus0.in_ready;
  assign rdy[1]  = bus1.in_ready;
  assign ovld[0] = bus0.out_valid;
  assign ovld[1] = {1'b0, bus1.out_valid};
  assign odat[0] = bus0.out_data;
  assign odat[1] = {8'h00, bus1.out_data};
  assign ocnt[0] = bus0.out_count;
  assign ocnt[1] = {3'b000, bus1.out_count};
  assign oerr[0] = bus0.err_invalid;
  assign oerr[1] = bus1.err_invalid;
  assign dcnt[0] = bus0.drop_count;
  assign dcnt[1] = bus1.drop_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q [2][4][$];
  int         drop_m [2];
  logic       err_m  [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int n;
    logic [1:0] er;
    logic [3:0] ev;
    logic [3:0] pv;
    #1;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 4 : 3;
      er[d] = !rst && (int'(in_priority) >= n ||
              q[d][in_priority].size() != 4);
      check($sformatf("rdy%0d", d), 32'(rdy[d]), 32'(er[d]));
      ev = '0;
      for (int c = 0; c < n; c++) begin
        ev[c] = q[d][c].size() != 0;
        check($sformatf("cnt%0d.%0d", d, c),
              32'(ocnt[d][c*3 +: 3]), 32'(q[d][c].size()));
        if (ev[c])
          check($sformatf("data%0d.%0d", d, c),
                32'(odat[d][c*8 +: 8]), 32'(q[d][c][0]));
      end
      check($sformatf("vld%0d", d), 32'(ovld[d]), 32'(ev));
      check($sformatf("err%0d", d), 32'(oerr[d]), 32'(err_m[d]));
      check($sformatf("drop%0d", d), 32'(dcnt[d]), 32'(drop_m[d]));
    end
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 4 : 3;
      if (rst) begin
        for (int c = 0; c < 4; c++) q[d][c].delete();
        drop_m[d] = 0;
        err_m[d]  = 1'b0;
      end else begin
        pv = '0;
        for (int c = 0; c < n; c++)
          pv[c] = q[d][c].size() != 0 && out_ready[c];
        for (int c = 0; c < n; c++)
          if (pv[c]) void'(q[d][c].pop_front());
        err_m[d] = 1'b0;
        if (in_valid && er[d]) begin
          if (int'(in_priority) < n) begin
            q[d][in_priority].push_back(in_data);
          end else begin
            err_m[d] = 1'b1;
            if (drop_m[d] < 255) drop_m[d]++;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_priority = 2'd0;
    out_ready = 4'h0;
    for (int d = 0; d < 2; d++) begin
      drop_m[d] = 0;
      err_m[d]  = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // basic route
    in_valid = 1'b1; in_priority = 2'd2; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    check("basic_vld", 32'(ovld[0]), 32'h4);
    check("basic_data", 32'(odat[0][23:16]), 32'hA5);
    check("basic_cnt", 32'(ocnt[0][8:6]), 32'd1);
    out_ready = 4'b0100;
    step();
    out_ready = 4'h0;
    check("basic_pop", 32'(ovld[0]), 32'h0);

    // fill and backpressure
    in_valid = 1'b1; in_priority = 2'd1;
    for (int k = 1; k <= 5; k++) begin
      in_data = 8'(k);
      if (k == 5) begin
        #1;
        check("fill_rdy5", 32'(rdy[0]), 32'd0);
      end
      step();
    end
    check("fill_cnt", 32'(ocnt[0][5:3]), 32'd4);
    in_valid = 1'b0;
    out_ready = 4'b0010;
    for (int k = 0; k < 4; k++) step();
    out_ready = 4'h0;

    // full with simultaneous pop: no bypass
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h30 + 8'(k);
      step();
    end
    out_ready = 4'b0010;
    in_data = 8'h55;
    #1;
    check("nobypass_rdy", 32'(rdy[0]), 32'd0);
    step();
    check("nobypass_cnt", 32'(ocnt[0][5:3]), 32'd3);
    #1;
    check("after_rdy", 32'(rdy[0]), 32'd1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    out_ready = 4'h0;

    // streaming through channel 0 with wrap
    out_ready = 4'b0001;
    in_valid = 1'b1; in_priority = 2'd0;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'h10 + 8'(k);
      step();
      check("stream_cnt", 32'(ocnt[0][2:0] <= 3'd1), 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 4'h0;

    // independence and invalid tags
    in_valid = 1'b1; in_priority = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h40 + 8'(k);
      step();
    end
    in_priority = 2'd1; in_data = 8'h77;
    #1;
    check("indep_rdy", 32'(rdy[1]), 32'd1);
    step();
    in_priority = 2'd3; in_data = 8'hEE;
    step();
    in_valid = 1'b0;
    check("drop_err", 32'(oerr[1]), 32'd1);
    check("drop_one", 32'(dcnt[1]), 32'd1);
    step();
    check("drop_pulse", 32'(oerr[1]), 32'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) step();
    in_valid = 1'b0;
    check("drop_sat", 32'(dcnt[1]), 32'd255);

    // reset mid-operation
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    in_priority = 2'd0;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'h60 + 8'(k);
      step();
    end
    in_priority = 2'd3;
    for (int k = 0; k < 2; k++) begin
      in_data = 8'h70 + 8'(k);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    out_ready = 4'hF;
    step();
    rst = 1'b0;
    check("rst_vld", 32'(ovld[0]), 32'h0);
    check("rst_cnt", 32'(ocnt[0]), 32'h0);
    for (int k = 0; k < 3; k++) step();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      rst         = ($urandom_range(0, 99) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_priority = 2'($urandom_range(0, 3));
      in_data     = 8'($urandom);
      out_ready   = 4'($urandom);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 4'hF;
    for (int k = 0; k < 6; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/priority_demux.md
# priority_demux

Receive-side counterpart of `priority_mux`. It accepts a single tagged stream (data plus priority tag) through a valid/ready handshake. The tag selects a destination channel, and each word is buffered in a per-channel FIFO. The block sits downstream of a shared link and fans words back out to `N_SIGNALS` consumers. Each consumer drains its own channel independently, so a stalled channel never blocks the others.

## Interface
- `N_PRIORITY_WIDTH`, default 2: width of the priority tag. Requires `N_SIGNALS <= 2**N_PRIORITY_WIDTH`.
- `N_SIGNAL_WIDTH`, default 8: data word width.
- `N_SIGNALS`, default 4: number of output channels.
- `N_FIFO_DEPTH`, default 4: words per channel FIFO. Power of two, at least 2. `CW = $clog2(N_FIFO_DEPTH)+1`.

Ports:
- `clk` input 1: the single clock; everything is on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: input word present.
- `in_ready` output 1: the block accepts the word this cycle.
- `in_data` input `N_SIGNAL_WIDTH`: input word.
- `in_priority` input `N_PRIORITY_WIDTH`: destination channel index.
- `out_valid` output `N_SIGNALS`: bit i means channel i FIFO is non-empty.
- `out_ready` input `N_SIGNALS`: bit i means consumer i takes its head word.
- `out_data` output `N_SIGNALS*N_SIGNAL_WIDTH`: channel i head word at bits `[i*N_SIGNAL_WIDTH +: N_SIGNAL_WIDTH]`.
- `out_count` output `N_SIGNALS*CW`: channel i occupancy (0..`N_FIFO_DEPTH`) at `[i*CW +: CW]`.
- `err_invalid` output 1: one-cycle pulse when a word with an out-of-range tag is dropped.
- `drop_count` output 8: saturating count of dropped words.

## Operation
- Accept: a transfer happens when `in_valid && in_ready`.
- Routing: for an accepted word with `in_priority < N_SIGNALS`, write `in_data` into FIFO[`in_priority`] at its write pointer; advance the pointer and increment the count.
- Invalid tag: `in_priority >= N_SIGNALS` is always accepted (`in_ready=1`).
  - The word is discarded.
  - `err_invalid` pulses on the next cycle.
  - `drop_count` increments and saturates at 255.
- `in_ready`, combinational, equals `!rst && (invalid tag || count[in_priority] != N_FIFO_DEPTH)`.
  - No bypass: a full FIFO refuses a push even if it pops in the same cycle.
- Pop: channel i pops when `out_valid[i] && out_ready[i]`. The read pointer advances and the count decrements. `out_ready[i]` while empty is ignored.
- Channels operate independently. Any set of channels may pop in the same cycle, alongside one push.
- Simultaneous push and pop on the same non-full channel: the count is unchanged and both pointers advance.
- Pointers are `$clog2(N_FIFO_DEPTH)` bits wide and wrap modulo the depth. Full and empty are decided from the count, never from pointer equality.
- Ordering: per channel, strict FIFO order. There is no ordering guarantee between channels.
- Storage RAM contents are not reset. Only pointers, counts and flags are reset.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `out_valid=0`, all counts 0, all pointers 0.
  - `err_invalid=0`, `drop_count=0`.
  - `in_ready=0` for as long as `rst` is high.
- Reset mid-operation: all FIFOs are flushed. Words in flight are lost and no pop is honoured in the reset cycle.
- Latency: a word accepted at edge t makes `out_valid[i]=1` with `out_data` equal to that word after edge t, i.e. 1 cycle from accept to visible head.
- Head data: `out_data` is read combinationally from RAM at the read pointer. It is stable while `out_valid[i]=1` and `out_ready[i]=0`.
- Full-channel throughput: 1 word per cycle per channel when the consumer holds `out_ready` high.
- `err_invalid` rises 1 cycle after the dropped accept and lasts exactly 1 cycle per dropped word. Back-to-back drops hold it high.

## Test plan
- Reset and basic route: after `rst`, push 0xA5 with tag 2 -> next cycle `out_valid=4'b0100`, channel 2 data 0xA5, count 1. Pop it -> `out_valid=0`.
- Fill and backpressure: push 5 words (0x01..0x05) to tag 1 with `out_ready=0` and depth 4 -> the first 4 are accepted and `in_ready=0` on the 5th. Count is 4. Draining yields 0x01..0x04 in order.
- Full, push plus pop: with channel 1 full and `out_ready[1]=1`, offer tag 1 -> `in_ready=0` (no bypass). Count goes to 3. The next cycle the push is accepted.
- Wrap-around and streaming: 10 consecutive words 0x10..0x19 to tag 0 with `out_ready[0]=1` -> all accepted at one per cycle and output in order. Count never exceeds 1.
- Independence and invalid tag (N_SIGNALS=3, width 2): with channel 0 stalled full, words to channel 1 are still accepted. A tag-3 word is accepted, `err_invalid` pulses once and `drop_count=1`. After 300 drops `drop_count=255`.
- Reset mid-operation: with 3 words in channel 0 and 2 in channel 3, assert `rst` for 1 cycle together with `out_ready=4'hF` -> all counts 0, `out_valid=0`, and no words are emitted afterwards.
